delay_line_controller: RTL and testbench

Initiator that drives the two-cycle handshake port of the banked contiguous SRAM as a circular delay buffer for the DSP sample stream. Each accepted input sample is written at the current write pointer inside a configurable window [base_addr, base_addr+buf_len). The sample `delay` positions back is then read and emitted as a one-cycle output pulse. The block sits between an effect stage's sample stream and the shared SRAM.

---
 rtl/delay_line_controller.sv | 91 +++++++++
 tb/tb_delay_line_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/delay_line_controller.sv
// delay_line_controller: drives a two-cycle-handshake SRAM as a circular delay buffer.
// Each sample is written at the window write pointer, then the tap `delay` back is read out.
module delay_line_controller #(
  parameter int data_width = 16,
  parameter int addr_width = 13,
  parameter int len_width  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [addr_width-1:0] base_addr,
  input  logic [len_width-1:0]  buf_len,
  input  logic [len_width-1:0]  delay,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  output logic                  sram_read,
  output logic [addr_width-1:0] sram_read_addr,
  input  logic                  sram_read_ready,
  output logic                  sram_write,
  output logic [addr_width-1:0] sram_write_addr,
  output logic [data_width-1:0] sram_wdata,
  input  logic [data_width-1:0] sram_rdata,
  input  logic                  sram_write_ready,
  input  logic                  sram_invalid_read,
  input  logic                  sram_invalid_write,
  output logic                  error
);
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_COMMIT, RD_ISSUE, RD_WAIT} state_t;
  state_t r_state;
  logic [len_width-1:0] r_wr_ptr, r_len;
  logic [len_width-1:0] w_len, w_d, w_wp, w_roff, w_next;
  logic [addr_width-1:0] w_wa, w_ra;
  assign w_len = (buf_len == '0) ? len_width'(1) : buf_len;
  assign w_d = (delay > w_len - len_width'(1)) ? w_len - len_width'(1) : delay;
  assign w_wp = (r_wr_ptr >= w_len) ? '0 : r_wr_ptr;
  // modular subtraction; the wrapped sum is always below w_len so truncation is harmless
  assign w_roff = (w_wp >= w_d) ? w_wp - w_d : w_wp + w_len - w_d;
  assign w_next = (r_wr_ptr + len_width'(1) == r_len) ? '0 : r_wr_ptr + len_width'(1);
  assign w_wa = base_addr + addr_width'(w_wp);
  assign w_ra = base_addr + addr_width'(w_roff);
  assign in_ready = (r_state == IDLE);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wr_ptr <= '0;
      r_len <= len_width'(1);
      out_valid <= 1'b0;
      out_data <= '0;
      error <= 1'b0;
      sram_read <= 1'b0;
      sram_write <= 1'b0;
      sram_read_addr <= '0;
      sram_write_addr <= '0;
      sram_wdata <= '0;
    end else begin
      error <= error | sram_invalid_read | sram_invalid_write;
      out_valid <= 1'b0;
      case (r_state)
        IDLE: if (in_valid) begin
          sram_wdata <= in_data;
          sram_write_addr <= w_wa;
          sram_read_addr <= w_ra;
          r_len <= w_len;
          r_wr_ptr <= w_wp;
          sram_write <= 1'b1;
          r_state <= WR_ISSUE;
        end
        WR_ISSUE: if (sram_write_ready) r_state <= WR_COMMIT;
        // SRAM commits on the second edge, so the request is held one extra cycle
        WR_COMMIT: begin
          sram_write <= 1'b0;
          sram_read <= 1'b1;
          r_state <= RD_ISSUE;
        end
        RD_ISSUE: if (sram_read_ready) begin
          sram_read <= 1'b0;
          r_state <= RD_WAIT;
        end
        RD_WAIT: if (sram_read_ready) begin
          out_data <= sram_rdata;
          out_valid <= 1'b1;
          r_wr_ptr <= w_next;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_delay_line_controller.sv
// tb_delay_line_controller: directed checks of the delay line against a behavioural SRAM.
module tb_delay_line_controller;
  logic clk, reset;
  logic [12:0] base, blen, dly;
  logic in_valid, in_ready, out_valid;
  logic [15:0] in_data, out_data;
  logic sram_read, sram_write, rd_rdy, wr_rdy, inv_r, inv_w, error;
  logic [12:0] sram_read_addr, sram_write_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic [15:0] mem [0:8191] = '{default: 16'h0};
  int checks = 0, errors = 0;

  delay_line_controller dut (
    .clk(clk), .reset(reset), .base_addr(base), .buf_len(blen), .delay(dly),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .sram_read(sram_read), .sram_read_addr(sram_read_addr), .sram_read_ready(rd_rdy),
    .sram_write(sram_write), .sram_write_addr(sram_write_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_write_ready(wr_rdy),
    .sram_invalid_read(inv_r), .sram_invalid_write(inv_w), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (sram_write) mem[sram_write_addr] <= sram_wdata;
  assign sram_rdata = mem[sram_read_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One sample end to end; ws/rs are stall cycles on write-ready and read-ready.
  task automatic send(input logic [15:0] d, input logic [15:0] exp, input logic [12:0] ewa,
                      input logic [12:0] era, input int ws, input int rs, input int elat);
    int lat = 0, wc = 0, rc = 0, rw = 0;
    bit both = 0, wbad = 0, rbad = 0;
    @(negedge clk);
    check("idle_out_valid", out_valid, 0);
    check("in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data = d;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 60) begin
      if (sram_write && sram_read) both = 1;
      if (sram_write) begin
        wc++;
        if (sram_write_addr !== ewa || sram_wdata !== d) wbad = 1;
        wr_rdy = (wc > ws);
      end else if (sram_read) begin
        rc++;
        if (sram_read_addr !== era) rbad = 1;
        rd_rdy = 1'b1;
      end else if (rc > 0) begin
        rw++;
        if (sram_read_addr !== era) rbad = 1;
        rd_rdy = (rw > rs);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    wr_rdy = 1'b1;
    rd_rdy = 1'b1;
    check("latency", lat, elat);
    check("out_data", out_data, exp);
    check("write_cycles", wc, ws + 2);
    check("read_cycles", rc, 1);
    check("no_overlap", both, 0);
    check("write_addr_data", wbad, 0);
    check("read_addr", rbad, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; base = '0; blen = '0; dly = '0;
    rd_rdy = 1'b1; wr_rdy = 1'b1; inv_r = 1'b0; inv_w = 1'b0;
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_error", error, 0);
    check("rst_sram_rw", {sram_read, sram_write}, 0);
    check("rst_addrs", {sram_read_addr, sram_write_addr, sram_wdata}, 0);

    // zero delay returns the sample just written
    base = 13'h100; blen = 13'd8; dly = 13'd0;
    send(16'h1111, 16'h1111, 13'h100, 13'h100, 0, 0, 5);
    send(16'h2222, 16'h2222, 13'h101, 13'h101, 0, 0, 5);

    // wrap: len 4, delay 3 reads the slot one ahead of the write
    do_reset();
    base = 13'h400; blen = 13'd4; dly = 13'd3;
    for (int i = 1; i <= 10; i++)
      send(16'(i), (i <= 3) ? 16'h0 : 16'(i - 3), 13'h400 + 13'((i - 1) % 4), 13'h400 + 13'(i % 4), 0, 0, 5);

    // delay clamps to len-1
    do_reset();
    base = 13'h600; blen = 13'd4; dly = 13'd9;
    for (int i = 1; i <= 10; i++)
      send(16'(i), (i <= 3) ? 16'h0 : 16'(i - 3), 13'h600 + 13'((i - 1) % 4), 13'h600 + 13'(i % 4), 0, 0, 5);
    // len 0 behaves as len 1; stale pointer (2) folds to 0
    base = 13'h700; blen = 13'd0; dly = 13'd5;
    send(16'h00A1, 16'h00A1, 13'h700, 13'h700, 0, 0, 5);
    send(16'h00A2, 16'h00A2, 13'h700, 13'h700, 0, 0, 5);

    // stalls
    do_reset();
    base = 13'h200; blen = 13'd8; dly = 13'd0;
    send(16'hBEEF, 16'hBEEF, 13'h200, 13'h200, 3, 4, 12);

    // sticky error, address wrap at top of SRAM
    do_reset();
    base = 13'h1FFE; blen = 13'd4; dly = 13'd0;
    @(negedge clk); inv_w = 1'b1;
    check("err_before_edge", error, 0);
    @(negedge clk); inv_w = 1'b0;
    check("err_set", error, 1);
    send(16'h0C01, 16'h0C01, 13'h1FFE, 13'h1FFE, 0, 0, 5);
    send(16'h0C02, 16'h0C02, 13'h1FFF, 13'h1FFF, 0, 0, 5);
    send(16'h0C03, 16'h0C03, 13'h0000, 13'h0000, 0, 0, 5);
    check("err_sticky", error, 1);
    do_reset();
    check("err_cleared", error, 0);
    @(negedge clk); inv_r = 1'b1;
    @(negedge clk); inv_r = 1'b0;
    check("err_read_flag", error, 1);

    // reset while in RD_WAIT
    do_reset();
    base = 13'h300; blen = 13'd8; dly = 13'd0;
    send(16'h3333, 16'h3333, 13'h300, 13'h300, 0, 0, 5);
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h4444;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_in_rd_wait", {in_ready, sram_read, sram_write}, 0);
    check("mid_wr_addr", sram_write_addr, 13'h301);
    rd_rdy = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_rdy = 1'b1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sram_read", sram_read, 0);
    send(16'h5555, 16'h5555, 13'h300, 13'h300, 0, 0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
